dma_xfer_cntr_v2: RTL and testbench

DMA_XFER_CNTR_V2 -- requirements
Module: dma_xfer_cntr_v2

---
 rtl/dma_xfer_cntr_v2.sv | 255 +++++++++++++++++++++++++
 tb/tb_dma_xfer_cntr_v2.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_cntr_v2.sv
// dma_xfer_cntr_v2
//
// Splits one host DMA transfer into PCI burst descriptors. The start byte
// address and length are turned into a word address, a word count, and
// active-low first/last byte-enable masks. A burst never crosses a
// BURST_WORDS-aligned word boundary. After a write (host to CNET) finishes,
// a wait counter runs down TX_WAIT_CYCLES cycles.
//
// Ports
//   clk_i           clock, rising edge
//   reset_i         asynchronous active-high reset
//   start_i         one-cycle request to begin a transfer (only honoured when idle)
//   xfer_is_rd_i    direction: 1 = CNET to host, 0 = host to CNET
//   host_addr_i     start byte address
//   xfer_len_i      transfer length in bytes
//   abort_i         cancel the transfer in progress
//   burst_req_o     burst descriptor valid
//   burst_grant_i   descriptor accepted by the PCI side
//   burst_addr_o    word address of the current burst
//   burst_words_o   word count of the current burst
//   first_be_o      active-low byte enables for the first word of the burst
//   last_be_o       active-low byte enables for the last word of the burst
//   data_vld_i      one word moved in the current burst
//   busy_o          a transfer is in progress
//   done_o          one-cycle pulse: transfer completed
//   aborted_o       one-cycle pulse: transfer was aborted
//   tx_wait_done_o  post-write wait counter is at zero

module dma_xfer_cntr_v2 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 12,
    parameter int WORD_BYTES     = 4,
    parameter int BURST_WORDS    = 16,
    parameter int TX_WAIT_CYCLES = 400
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        start_i,
    input  logic                                        xfer_is_rd_i,
    input  logic [ADDR_WIDTH-1:0]                       host_addr_i,
    input  logic [LEN_WIDTH-1:0]                        xfer_len_i,
    input  logic                                        abort_i,
    output logic                                        burst_req_o,
    input  logic                                        burst_grant_i,
    output logic [ADDR_WIDTH-$clog2(WORD_BYTES)-1:0]    burst_addr_o,
    output logic [$clog2(BURST_WORDS):0]                burst_words_o,
    output logic [WORD_BYTES-1:0]                       first_be_o,
    output logic [WORD_BYTES-1:0]                       last_be_o,
    input  logic                                        data_vld_i,
    output logic                                        busy_o,
    output logic                                        done_o,
    output logic                                        aborted_o,
    output logic                                        tx_wait_done_o
);

    localparam int WB_LOG2 = $clog2(WORD_BYTES);
    localparam int BW_LOG2 = $clog2(BURST_WORDS);
    localparam int WAW     = ADDR_WIDTH - WB_LOG2;
    localparam int BCW     = BW_LOG2 + 1;
    // Two spare bits so offset + length and the rounded-up word count cannot overflow
    localparam int RW      = LEN_WIDTH + 2;
    localparam int TXW     = $clog2(TX_WAIT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        REQ,
        BURST,
        DONE
    } state_t;

    state_t                 state_q, state_d;

    logic                   rd_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   len_q;

    logic [WAW-1:0]         curWord_q, curWord_d;
    logic [RW-1:0]          remWords_q, remWords_d;
    logic [BCW-1:0]         burstCnt_q, burstCnt_d;
    logic                   firstBurst_q, firstBurst_d;

    logic [WAW-1:0]         burstAddr_q;
    logic [BCW-1:0]         burstWords_q;
    logic [WORD_BYTES-1:0]  firstBe_q, lastBe_q;

    logic                   aborted_q;
    logic [TXW-1:0]         txWait_q;

    logic [WB_LOG2-1:0]     offset;
    logic [RW-1:0]          byteSpan;
    logic [RW-1:0]          totalWords;
    logic [WB_LOG2-1:0]     endLane;
    logic                   singleWord;
    logic [WORD_BYTES-1:0]  loMask, hiMask;

    logic [31:0]            curInBurst, spaceWords, remWords32, descWords;
    logic                   descIsLast;
    logic                   loadDesc;
    logic                   aborting;

    assign aborting = (state_q != IDLE) && abort_i;

    // Transfer geometry, derived from the captured address and length
    always_comb begin
        offset     = addr_q[WB_LOG2-1:0];
        byteSpan   = RW'(offset) + RW'(len_q);
        totalWords = (byteSpan + RW'(WORD_BYTES - 1)) >> WB_LOG2;
        endLane    = byteSpan[WB_LOG2-1:0];
        singleWord = (totalWords == RW'(1));
        loMask     = '0;
        hiMask     = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            loMask[i] = (i < int'(offset));
            hiMask[i] = (endLane != '0) && (i >= int'(endLane));
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_d = state_q;
        if (aborting) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = CALC;
                CALC:    state_d = (len_q == '0) ? DONE : REQ;
                REQ:     if (burst_grant_i) state_d = BURST;
                BURST:   if (burstCnt_d == '0) state_d = (remWords_d != '0) ? REQ : DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy_o      = (state_q != IDLE);
        burst_req_o = (state_q == REQ);
        done_o      = (state_q == DONE) && !abort_i;
    end

    // Word pointer, remaining words and per-burst countdown
    always_comb begin
        curWord_d    = curWord_q;
        remWords_d   = remWords_q;
        burstCnt_d   = burstCnt_q;
        firstBurst_d = firstBurst_q;
        if (!aborting) begin
            case (state_q)
                CALC: begin
                    curWord_d    = addr_q[ADDR_WIDTH-1:WB_LOG2];
                    remWords_d   = totalWords;
                    firstBurst_d = 1'b1;
                end
                REQ: begin
                    if (burst_grant_i) begin
                        burstCnt_d   = burstWords_q;
                        firstBurst_d = 1'b0;
                    end
                end
                BURST: begin
                    if (data_vld_i && (burstCnt_q != '0)) begin
                        curWord_d  = curWord_q + WAW'(1);
                        remWords_d = remWords_q - RW'(1);
                        burstCnt_d = burstCnt_q - BCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next burst descriptor, computed from the pointer values that will be
    // current when REQ is entered so it is ready in the first REQ cycle.
    // curInBurst only needs the low bits, so truncating to 32 is safe.
    always_comb begin
        curInBurst = 32'(curWord_d & WAW'(BURST_WORDS - 1));
        spaceWords = 32'(BURST_WORDS) - curInBurst;
        remWords32 = 32'(remWords_d);
        descWords  = (remWords32 < spaceWords) ? remWords32 : spaceWords;
        descIsLast = (remWords32 <= spaceWords);
        loadDesc   = (state_d == REQ) && (state_q != REQ);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_q         <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            curWord_q    <= '0;
            remWords_q   <= '0;
            burstCnt_q   <= '0;
            firstBurst_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start_i) begin
                rd_q   <= xfer_is_rd_i;
                addr_q <= host_addr_i;
                len_q  <= xfer_len_i;
            end
            curWord_q    <= curWord_d;
            remWords_q   <= remWords_d;
            burstCnt_q   <= burstCnt_d;
            firstBurst_q <= firstBurst_d;
        end
    end

    // Descriptor registers hold from REQ entry through the end of BURST.
    // A one-word transfer gets the combined mask on both enables.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            burstAddr_q  <= '0;
            burstWords_q <= '0;
            firstBe_q    <= '0;
            lastBe_q     <= '0;
        end else if (loadDesc) begin
            burstAddr_q  <= curWord_d;
            burstWords_q <= BCW'(descWords);
            firstBe_q    <= firstBurst_d ? (singleWord ? (loMask | hiMask) : loMask) : '0;
            lastBe_q     <= descIsLast   ? (singleWord ? (loMask | hiMask) : hiMask) : '0;
        end
    end

    // Abort pulse lands in the first IDLE cycle; post-write wait counter
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            aborted_q <= 1'b0;
            txWait_q  <= '0;
        end else begin
            aborted_q <= aborting;
            if ((state_q == DONE) && !abort_i && !rd_q) begin
                txWait_q <= TXW'(TX_WAIT_CYCLES);
            end else if (txWait_q != '0) begin
                txWait_q <= txWait_q - TXW'(1);
            end
        end
    end

    assign burst_addr_o   = burstAddr_q;
    assign burst_words_o  = burstWords_q;
    assign first_be_o     = firstBe_q;
    assign last_be_o      = lastBe_q;
    assign aborted_o      = aborted_q;
    assign tx_wait_done_o = (txWait_q == '0);

endmodule

// File: tb/tb_dma_xfer_cntr_v2.sv
// Testbench for dma_xfer_cntr_v2: a 4-byte-word instance driven by a table
// of transfers with hand-computed descriptors, plus hand-written sequences
// for reset, zero length, post-write wait, abort, reset mid-transfer, and
// an 8-byte-word instance with a stalled grant.

module tb_dma_xfer_cntr_v2;

    logic        clk = 1'b0;
    logic        reset;

    // 4-byte-word instance
    logic        start, rd, abort, grant, vld;
    logic [31:0] addr;
    logic [11:0] len;
    logic        burstReq, busy, done, aborted, txDone;
    logic [29:0] burstAddr;
    logic [4:0]  burstWords;
    logic [3:0]  firstBe, lastBe;

    // 8-byte-word instance
    logic        start8, rd8, abort8, grant8, vld8;
    logic [31:0] addr8;
    logic [11:0] len8;
    logic        burstReq8, busy8, done8, aborted8, txDone8;
    logic [28:0] burstAddr8;
    logic [4:0]  burstWords8;
    logic [7:0]  firstBe8, lastBe8;

    int nVectors = 0;
    int nMiscompares = 0;

    always #5 clk = ~clk;

    dma_xfer_cntr_v2 dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .xfer_is_rd_i(rd),
        .host_addr_i(addr), .xfer_len_i(len), .abort_i(abort),
        .burst_req_o(burstReq), .burst_grant_i(grant), .burst_addr_o(burstAddr),
        .burst_words_o(burstWords), .first_be_o(firstBe), .last_be_o(lastBe),
        .data_vld_i(vld), .busy_o(busy), .done_o(done), .aborted_o(aborted),
        .tx_wait_done_o(txDone)
    );

    dma_xfer_cntr_v2 #(.WORD_BYTES(8)) dut8 (
        .clk_i(clk), .reset_i(reset), .start_i(start8), .xfer_is_rd_i(rd8),
        .host_addr_i(addr8), .xfer_len_i(len8), .abort_i(abort8),
        .burst_req_o(burstReq8), .burst_grant_i(grant8), .burst_addr_o(burstAddr8),
        .burst_words_o(burstWords8), .first_be_o(firstBe8), .last_be_o(lastBe8),
        .data_vld_i(vld8), .busy_o(busy8), .done_o(done8), .aborted_o(aborted8),
        .tx_wait_done_o(txDone8)
    );

    typedef struct {
        logic            rd;
        logic [31:0]     addr;
        logic [11:0]     len;
        int              nb;
        logic [2:0][29:0] ba;
        logic [2:0][4:0]  bw;
        logic [2:0][3:0]  fbe;
        logic [2:0][3:0]  lbe;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic setVec(input int i, input logic r, input logic [31:0] a, input logic [11:0] l);
        vecs[i].rd   = r;
        vecs[i].addr = a;
        vecs[i].len  = l;
        vecs[i].nb   = 0;
        vecs[i].ba   = '0;
        vecs[i].bw   = '0;
        vecs[i].fbe  = '0;
        vecs[i].lbe  = '0;
    endtask

    task automatic addBurst(input int i, input logic [29:0] a, input logic [4:0] w,
                            input logic [3:0] f, input logic [3:0] l);
        int b;
        b = vecs[i].nb;
        vecs[i].ba[b]  = a;
        vecs[i].bw[b]  = w;
        vecs[i].fbe[b] = f;
        vecs[i].lbe[b] = l;
        vecs[i].nb     = b + 1;
    endtask

    // Runs one transfer on the 4-byte instance, checking every descriptor
    task automatic applyStimulus(input vec_t v);
        int  cnt;
        bit  sawReq;
        @(negedge clk);
        rd = v.rd; addr = v.addr; len = v.len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < v.nb; b++) begin
            cnt = 0;
            while (!burstReq && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            if (!burstReq) begin
                checkOutput("burst_req timeout", 64'(burstReq), 64'd1);
                return;
            end
            checkOutput("burst_addr", 64'(burstAddr), 64'(v.ba[b]));
            checkOutput("burst_words", 64'(burstWords), 64'(v.bw[b]));
            checkOutput("first_be", 64'(firstBe), 64'(v.fbe[b]));
            checkOutput("last_be", 64'(lastBe), 64'(v.lbe[b]));
            grant = 1'b1;
            @(negedge clk);
            grant = 1'b0;
            checkOutput("burst_req after grant", 64'(burstReq), 64'd0);
            for (int w = 0; w < int'(v.bw[b]); w++) begin
                vld = 1'b1;
                @(negedge clk);
            end
            vld = 1'b0;
        end
        cnt = 0;
        sawReq = 1'b0;
        while (!done && cnt < 20) begin
            if (burstReq) sawReq = 1'b1;
            @(negedge clk);
            cnt++;
        end
        checkOutput("done seen", 64'(done), 64'd1);
        checkOutput("no extra burst", 64'(sawReq), 64'd0);
        @(negedge clk);
        checkOutput("busy after done", 64'(busy), 64'd0);
    endtask

    initial begin
        int cnt;
        int lowCnt;

        reset = 1'b1;
        start = 0; rd = 0; abort = 0; grant = 0; vld = 0; addr = '0; len = '0;
        start8 = 0; rd8 = 0; abort8 = 0; grant8 = 0; vld8 = 0; addr8 = '0; len8 = '0;

        setVec(0, 1'b0, 32'h40, 12'd64);
        addBurst(0, 30'h10, 5'd16, 4'b0000, 4'b0000);
        setVec(1, 1'b1, 32'h3E, 12'd8);
        addBurst(1, 30'hF, 5'd1, 4'b0011, 4'b0000);
        addBurst(1, 30'h10, 5'd2, 4'b0000, 4'b1100);
        setVec(2, 1'b1, 32'h101, 12'd2);
        addBurst(2, 30'h40, 5'd1, 4'b1001, 4'b1001);
        setVec(3, 1'b0, 32'h55, 12'd0);
        setVec(4, 1'b0, 32'h0, 12'd1);
        addBurst(4, 30'h0, 5'd1, 4'b1110, 4'b1110);
        setVec(5, 1'b1, 32'h3C, 12'd72);
        addBurst(5, 30'hF, 5'd1, 4'b0000, 4'b0000);
        addBurst(5, 30'h10, 5'd16, 4'b0000, 4'b0000);
        addBurst(5, 30'h20, 5'd1, 4'b0000, 4'b0000);
        setVec(6, 1'b1, 32'h7, 12'd6);
        addBurst(6, 30'h1, 5'd3, 4'b0111, 4'b1110);
        setVec(7, 1'b0, 32'hFFFF_FFFC, 12'd8);
        addBurst(7, 30'h3FFF_FFFF, 5'd1, 4'b0000, 4'b0000);
        addBurst(7, 30'h0, 5'd1, 4'b0000, 4'b0000);
        setVec(8, 1'b0, 32'h2, 12'd3);
        addBurst(8, 30'h0, 5'd2, 4'b0011, 4'b1110);

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset burst_req", 64'(burstReq), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset aborted", 64'(aborted), 64'd0);
        checkOutput("reset burst_addr", 64'(burstAddr), 64'd0);
        checkOutput("reset burst_words", 64'(burstWords), 64'd0);
        checkOutput("reset first_be", 64'(firstBe), 64'd0);
        checkOutput("reset last_be", 64'(lastBe), 64'd0);
        checkOutput("reset tx_wait_done", 64'(txDone), 64'd1);
        reset = 1'b0;

        // Table-driven transfers
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        // Zero length: done exactly two cycles after start, no burst
        @(negedge clk);
        rd = 1'b1; addr = 32'h10; len = 12'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("len0 busy", 64'(busy), 64'd1);
        checkOutput("len0 done early", 64'(done), 64'd0);
        @(negedge clk);
        checkOutput("len0 done", 64'(done), 64'd1);
        checkOutput("len0 burst_req", 64'(burstReq), 64'd0);
        @(negedge clk);
        checkOutput("len0 done pulse", 64'(done), 64'd0);
        checkOutput("len0 idle", 64'(busy), 64'd0);

        // Write completion starts a 400-cycle wait
        applyStimulus(vecs[0]);
        lowCnt = 0;
        while (!txDone && lowCnt < 600) begin
            lowCnt++;
            @(negedge clk);
        end
        checkOutput("tx wait length", 64'(lowCnt), 64'd400);

        // Abort after 3 of 16 words
        @(negedge clk);
        rd = 1'b0; addr = 32'h40; len = 12'd64; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!burstReq && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("abort burst_req", 64'(burstReq), 64'd1);
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        repeat (3) begin
            vld = 1'b1;
            @(negedge clk);
        end
        vld = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("aborted pulse", 64'(aborted), 64'd1);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort burst_req", 64'(burstReq), 64'd0);
        checkOutput("abort no done", 64'(done), 64'd0);
        @(negedge clk);
        checkOutput("aborted one cycle", 64'(aborted), 64'd0);
        checkOutput("abort no later done", 64'(done), 64'd0);
        applyStimulus(vecs[1]);

        // Reset in the middle of a burst: no done, no aborted
        @(negedge clk);
        rd = 1'b1; addr = 32'h3C; len = 12'd72; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset burst_words", 64'(burstWords), 64'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("midreset no done", 64'(done), 64'd0);
            checkOutput("midreset no aborted", 64'(aborted), 64'd0);
        end

        // 8-byte words, stalled grant with stray data_vld in REQ
        @(negedge clk);
        rd8 = 1'b1; addr8 = 32'h7; len8 = 12'd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cnt = 0;
        while (!burstReq8 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput("w8 burst_req", 64'(burstReq8), 64'd1);
            checkOutput("w8 burst_addr", 64'(burstAddr8), 64'd0);
            checkOutput("w8 burst_words", 64'(burstWords8), 64'd2);
            checkOutput("w8 first_be", 64'(firstBe8), 64'h7F);
            checkOutput("w8 last_be", 64'(lastBe8), 64'h00);
            vld8 = 1'b1;
            @(negedge clk);
        end
        vld8 = 1'b0;
        grant8 = 1'b1;
        @(negedge clk);
        grant8 = 1'b0;
        checkOutput("w8 req after grant", 64'(burstReq8), 64'd0);
        checkOutput("w8 words held", 64'(burstWords8), 64'd2);
        vld8 = 1'b1;
        @(negedge clk);
        checkOutput("w8 not done after 1", 64'(done8), 64'd0);
        @(negedge clk);
        vld8 = 1'b0;
        checkOutput("w8 done", 64'(done8), 64'd1);
        checkOutput("w8 no second burst", 64'(burstReq8), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
